tlk2711_dma_cmd_arb: RTL

//  Round-robin scheduler that shares one tlk2711_dma command channel between NUM_REQ requesters.

---
 rtl/tlk2711_dma_cmd_arb.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tlk2711_dma_cmd_arb.sv
// Round-robin arbiter sharing one tlk2711_dma read-command channel between NUM_REQ requesters.
// Optional WAIT_LAST watchdog enabled by defining TLK2711_CMD_ARB_TIMEOUT_EN.
module tlk2711_dma_cmd_arb #(
  parameter int ADDR_WIDTH     = 48,
  parameter int DLEN_WIDTH     = 16,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_soft_rst,
  input  logic [NUM_REQ-1:0]                          i_req,
  input  logic [NUM_REQ*(DLEN_WIDTH+ADDR_WIDTH)-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]                          o_req_ack,
  output logic [NUM_REQ-1:0]                          o_done,
  output logic                                        o_cmd_req,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0]            o_cmd_data,
  input  logic                                        i_cmd_ack,
  input  logic                                        i_dma_last,
  output logic [$clog2(NUM_REQ)-1:0]                  o_grant_id,
  output logic                                        o_busy,
  output logic                                        o_timeout
);

  localparam int CMD_W = DLEN_WIDTH + ADDR_WIDTH;
  localparam int ID_W  = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("tlk2711_dma_cmd_arb: unsupported parameter value");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LAST} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic                  cmd_req_d;
  logic [CMD_W-1:0]      cmd_data_d;
  logic [ID_W-1:0]       grant_d;
  logic [NUM_REQ-1:0]    req_ack_d, done_d;
  logic [NUM_REQ-1:0]    req_avail;
  logic [CMD_W-1:0]      slice [NUM_REQ];
  logic [CMD_W-1:0]      sel_slice;
  logic [ID_W-1:0]       winner;
  logic                  found;
  int                    idx;

  function automatic logic [ID_W-1:0] inc_ptr(input logic [ID_W-1:0] g);
    return (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] g);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign slice[k] = i_req_data[k*CMD_W +: CMD_W];
  end

  // A requester whose ack is visible this cycle has not yet dropped i_req; do not grant it twice.
  assign req_avail = i_req & ~o_req_ack;
  assign o_busy    = (state_q != IDLE);

`ifdef TLK2711_CMD_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt_q;
  logic        timeout_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q  <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_d;
      if (state_q == WAIT_LAST && !i_soft_rst) wd_cnt_q <= wd_cnt_q + 32'd1;
      else                                     wd_cnt_q <= '0;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cmd_req_d  = o_cmd_req;
    cmd_data_d = o_cmd_data;
    grant_d    = o_grant_id;
    req_ack_d  = '0;
    done_d     = '0;
    found      = 1'b0;
    winner     = '0;
    idx        = 0;
`ifdef TLK2711_CMD_ARB_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif

    // Rotate the search start to the pointer; first pending requester wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_avail[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
    sel_slice = slice[winner];

    case (state_q)
      IDLE: begin
        if (found) begin
          cmd_data_d = sel_slice;
          grant_d    = winner;
          if (sel_slice[CMD_W-1:ADDR_WIDTH] == '0) begin
            req_ack_d = onehot(winner);
            done_d    = onehot(winner);
            ptr_d     = inc_ptr(winner);
          end else begin
            cmd_req_d = 1'b1;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (i_cmd_ack) begin
          cmd_req_d = 1'b0;
          req_ack_d = onehot(o_grant_id);
          if (i_dma_last) begin
            done_d  = onehot(o_grant_id);
            ptr_d   = inc_ptr(o_grant_id);
            state_d = IDLE;
          end else begin
            state_d = WAIT_LAST;
          end
        end
      end
      WAIT_LAST: begin
        if (i_dma_last) begin
          done_d  = onehot(o_grant_id);
          ptr_d   = inc_ptr(o_grant_id);
          state_d = IDLE;
        end
`ifdef TLK2711_CMD_ARB_TIMEOUT_EN
        else if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          ptr_d     = inc_ptr(o_grant_id);
          state_d   = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (i_soft_rst) begin
      state_d   = IDLE;
      ptr_d     = '0;
      cmd_req_d = 1'b0;
      req_ack_d = '0;
      done_d    = '0;
`ifdef TLK2711_CMD_ARB_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      o_cmd_req  <= 1'b0;
      o_cmd_data <= '0;
      o_grant_id <= '0;
      o_req_ack  <= '0;
      o_done     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      o_cmd_req  <= cmd_req_d;
      o_cmd_data <= cmd_data_d;
      o_grant_id <= grant_d;
      o_req_ack  <= req_ack_d;
      o_done     <= done_d;
    end
  end

endmodule
